req_ack_target: RTL and testbench

Synthesizable responder for the single-cycle request/acknowledge bus (`bus_req`, `bus_ack`, `bus_data`) that the `$assert_req_ack` checks monitor. It sits directly downstream of the request generator. It accepts one pulsed request at a time and captures its data. After a fixed minimum latency it returns a one-cycle `bus_ack`. Captured words are queued in a small FIFO and drained through a valid/ready port. When the FIFO is full, the ack is withheld, which gives the requester backpressure.

---
 rtl/req_ack_target.sv | 139 +++++++++++++
 tb/tb_req_ack_target.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_target.sv
// Single-cycle req/ack bus responder: captures one request at a time, acks after a
// fixed minimum latency, and queues captured words in a FWFT FIFO drained via valid/ready.
module req_ack_target #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ACK_DELAY = 2
) (
    input  logic                         clk,
    input  logic                         reset_l,
    input  logic                         bus_req,
    input  logic [DATA_W-1:0]            bus_data,
    output logic                         bus_ack,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         protocol_err
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(ACK_DELAY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                ack_q;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]    count_q, count_d;
    logic                valid_q;

    logic                push;
    logic                pop;
    logic                space;

    assign pop   = valid_q && out_ready;
    assign push  = (state_q == S_ACK);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the ack.
    assign space = (count_q < OCC_W'(DEPTH)) || pop;

    // Next-state logic for the request/ack handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus_req) begin
                    hold_d  = bus_data;
                    cnt_d   = CNT_W'(ACK_DELAY - 2);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (space) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus_req && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ack_q   <= (state_d == S_ACK);
            err_q   <= err_d;
        end
    end

    // FIFO occupancy update.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= hold_q;
        end
    end

    assign bus_ack      = ack_q;
    assign out_valid    = valid_q;
    assign out_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_req_ack_target.sv
// Bench for req_ack_target: directed scenarios plus a cycle/queue reference model
// compared against every DUT output on each falling clock edge.
module tb_req_ack_target;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned ACK_DELAY = 2;

    logic              clk = 1'b0;
    logic              reset_l = 1'b0;
    logic              bus_req = 1'b0;
    logic [DATA_W-1:0] bus_data = '0;
    logic              out_ready = 1'b0;
    logic              bus_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        count;
    logic              protocol_err;

    req_ack_target #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ACK_DELAY(ACK_DELAY)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .bus_req     (bus_req),
        .bus_data    (bus_data),
        .bus_ack     (bus_ack),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: a pending request acks once its due cycle has come and the
    // queue has room (or is being drained that cycle); accepted words join a queue.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_hold = '0;
    bit m_ack = 0, m_busy = 0, m_err = 0;
    int cyc = 0, m_due = 0;

    initial forever begin
        bit pop_m, full_m, next_ack, was_busy;
        @(posedge clk or negedge reset_l);
        if (!reset_l) begin
            q.delete();
            m_ack = 0; m_busy = 0; m_err = 0;
        end else begin
            cyc++;
            pop_m    = (q.size() > 0) && out_ready;
            full_m   = (q.size() >= DEPTH);
            was_busy = m_busy;
            next_ack = 0;
            if (pop_m) void'(q.pop_front());
            if (m_ack) begin
                q.push_back(m_hold);
                m_busy = 0;
            end else if (m_busy && cyc >= m_due - 1 && (!full_m || pop_m)) begin
                next_ack = 1;
            end
            if (bus_req) begin
                if (was_busy) m_err = 1;
                else begin
                    m_busy = 1;
                    m_hold = bus_data;
                    m_due  = cyc + ACK_DELAY;
                end
            end
            m_ack = next_ack;
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_ack", {63'd0, bus_ack}, {63'd0, m_ack});
            check("m_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            check("m_count", {61'd0, count}, 64'(q.size()));
            check("m_err", {63'd0, protocol_err}, {63'd0, m_err});
            if (q.size() > 0) check("m_data", {32'd0, out_data}, {32'd0, q[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        tick();
        tick();
        reset_l = 1'b1;
    endtask

    // Legal request followed by the full req/wait/ack window (3 cycles).
    task automatic xfer(input logic [DATA_W-1:0] d);
        bus_req = 1'b1; bus_data = d;
        tick();
        bus_req = 1'b0;
        tick();
        check("xfer_ack", {63'd0, bus_ack}, 64'd1);
        tick();
    endtask

    logic [DATA_W-1:0] exp6 [12];

    initial begin
        tick();
        tick();
        check("rst_ack", {63'd0, bus_ack}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_err", {63'd0, protocol_err}, 64'd0);
        reset_l = 1'b1;
        chk_en  = 1'b1;

        // Single transfer
        out_ready = 1'b1;
        bus_req = 1'b1; bus_data = 32'hfeed;
        tick();
        bus_req = 1'b0;
        check("t1_wait_ack", {63'd0, bus_ack}, 64'd0);
        tick();
        check("t1_ack", {63'd0, bus_ack}, 64'd1);
        tick();
        check("t1_ack_off", {63'd0, bus_ack}, 64'd0);
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_data", {32'd0, out_data}, 64'hfeed);
        check("t1_count1", {61'd0, count}, 64'd1);
        tick();
        check("t1_count0", {61'd0, count}, 64'd0);
        check("t1_valid0", {63'd0, out_valid}, 64'd0);
        check("t1_err", {63'd0, protocol_err}, 64'd0);

        // Fill and stall
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) xfer(32'(i));
        check("t2_full", {61'd0, count}, 64'd4);
        bus_req = 1'b1; bus_data = 32'd5;
        tick();
        bus_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_ack", {63'd0, bus_ack}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_late_ack", {63'd0, bus_ack}, 64'd1);
        check("t2_head2", {32'd0, out_data}, 64'd2);
        check("t2_count3", {61'd0, count}, 64'd3);
        tick();
        check("t2_count4", {61'd0, count}, 64'd4);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("t2_drain", {32'd0, out_data}, 64'(k));
            tick();
        end
        check("t2_empty", {61'd0, count}, 64'd0);

        // Held request
        bus_req = 1'b1; bus_data = 32'haaaa;
        tick();
        bus_data = 32'hbbbb;
        check("t3_err_not_yet", {63'd0, protocol_err}, 64'd0);
        tick();
        bus_req = 1'b0;
        check("t3_ack", {63'd0, bus_ack}, 64'd1);
        check("t3_err", {63'd0, protocol_err}, 64'd1);
        tick();
        check("t3_data", {32'd0, out_data}, 64'haaaa);
        check("t3_count", {61'd0, count}, 64'd1);
        tick();
        tick();
        check("t3_no_b", {61'd0, count}, 64'd0);
        check("t3_sticky", {63'd0, protocol_err}, 64'd1);
        do_reset();
        check("t3_err_clr", {63'd0, protocol_err}, 64'd0);

        // Request during ack cycle
        bus_req = 1'b1; bus_data = 32'ha1;
        tick();
        bus_req = 1'b0;
        tick();
        bus_req = 1'b1; bus_data = 32'hb2;
        check("t4_ack", {63'd0, bus_ack}, 64'd1);
        tick();
        bus_req = 1'b0;
        check("t4_err", {63'd0, protocol_err}, 64'd1);
        check("t4_data", {32'd0, out_data}, 64'ha1);
        tick();
        check("t4_dropped", {63'd0, bus_ack}, 64'd0);
        xfer(32'hc3);
        check("t4_next", {32'd0, out_data}, 64'hc3);
        tick();
        do_reset();

        // Reset mid-WAIT
        out_ready = 1'b0;
        xfer(32'h77);
        bus_req = 1'b1; bus_data = 32'h88;
        tick();
        bus_req = 1'b0;
        #2;
        reset_l = 1'b0;
        #1;
        check("t5_ack", {63'd0, bus_ack}, 64'd0);
        check("t5_valid", {63'd0, out_valid}, 64'd0);
        check("t5_count", {61'd0, count}, 64'd0);
        check("t5_err", {63'd0, protocol_err}, 64'd0);
        tick();
        tick();
        reset_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_no_ack", {63'd0, bus_ack}, 64'd0);
            tick();
        end
        xfer(32'h99);
        check("t5_after", {32'd0, out_data}, 64'h99);
        do_reset();

        // Push/pop around full with pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp6[i] = 32'(10 + i);
        for (int i = 0; i < 8; i++) exp6[4 + i] = 32'(20 + i);
        for (int i = 0; i < 4; i++) xfer(exp6[i]);
        for (int i = 0; i < 8; i++) begin
            bus_req = 1'b1; bus_data = exp6[4 + i];
            tick();
            bus_req = 1'b0;
            out_ready = 1'b1;
            check("t6_full", {61'd0, count}, 64'd4);
            tick();
            out_ready = 1'b0;
            check("t6_ack", {63'd0, bus_ack}, 64'd1);
            tick();
            check("t6_refill", {61'd0, count}, 64'd4);
            check("t6_head", {32'd0, out_data}, {32'd0, exp6[i + 1]});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t6_drain", {32'd0, out_data}, {32'd0, exp6[8 + k]});
            tick();
        end
        check("t6_empty", {61'd0, count}, 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
